// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg: shared widths, load funct3 encodings and skid state for wb_stage.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package wb_stage_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 64;

    localparam logic [XLEN-1:0] ZeroWord = '0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_stage_load_align.sv
// -----------------------------------------------------------------------------
// wb_stage_load_align: extracts byte/half/word from an aligned load word and extends it.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    // A misaligned halfword simply takes the half picked by offset[1].
    assign byte_w = 8'(word_i >> {offset_i, 3'b000});
    assign half_w = 16'(word_i >> {offset_i[1], 4'b0000});

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_w[7]}}, byte_w};
            F3_LH:   data_o = {{(XLEN-16){half_w[15]}}, half_w};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_w};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_w};
            default: data_o = word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage: merges execute results and load responses onto the regfile write port.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wb_stage
    import wb_stage_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [RADDR_W-1:0] ld_rd,
    input  logic [2:0]         ld_funct3,
    input  logic [1:0]         ld_offset,
    input  logic [XLEN-1:0]    ld_word,
    output logic               write_flag,
    output logic [RADDR_W-1:0] reg_write,
    output logic [XLEN-1:0]    write_data,
    output logic [CNT_W-1:0]   retire_count
);

    skid_state_e        skid_q;
    logic [RADDR_W-1:0] skid_rd_q;
    logic [XLEN-1:0]    skid_data_q;

    logic               write_flag_q;
    logic [RADDR_W-1:0] reg_write_q;
    logic [XLEN-1:0]    write_data_q;
    logic [CNT_W-1:0]   retire_count_q;

    logic               ld_fire;
    logic               ex_fire;
    logic               skid_drain;
    logic [XLEN-1:0]    ld_data;

    logic               sel_valid_d;
    logic [RADDR_W-1:0] sel_rd_d;
    logic [XLEN-1:0]    sel_data_d;

    wb_stage_load_align u_load_align (
        .word_i   (ld_word),
        .funct3_i (ld_funct3),
        .offset_i (ld_offset),
        .data_o   (ld_data)
    );

    assign ld_ready   = rdy_in;
    assign ex_ready   = rdy_in && (skid_q == SKID_EMPTY);
    assign ld_fire    = ld_valid && rdy_in;
    assign ex_fire    = ex_valid && ex_ready;
    assign skid_drain = rdy_in && !ld_valid && (skid_q == SKID_FULL);

    // Loads cannot be back-pressured by execute, so they always win the port.
    always_comb begin
        sel_valid_d = 1'b0;
        sel_rd_d    = ex_rd;
        sel_data_d  = ex_data;
        if (ld_fire) begin
            sel_valid_d = 1'b1;
            sel_rd_d    = ld_rd;
            sel_data_d  = ld_data;
        end else if (skid_drain) begin
            sel_valid_d = 1'b1;
            sel_rd_d    = skid_rd_q;
            sel_data_d  = skid_data_q;
        end else if (ex_fire) begin
            sel_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            skid_q         <= SKID_EMPTY;
            skid_rd_q      <= '0;
            skid_data_q    <= ZeroWord;
            write_flag_q   <= 1'b0;
            reg_write_q    <= '0;
            write_data_q   <= ZeroWord;
            retire_count_q <= '0;
        end else begin
            case (skid_q)
                SKID_EMPTY: begin
                    if (ex_fire && ld_fire) begin
                        skid_q      <= SKID_FULL;
                        skid_rd_q   <= ex_rd;
                        skid_data_q <= ex_data;
                    end
                end
                SKID_FULL: begin
                    if (skid_drain) begin
                        skid_q <= SKID_EMPTY;
                    end
                end
                default: skid_q <= SKID_EMPTY;
            endcase

            // Writes to x0 still retire and still move the index/data registers.
            write_flag_q <= sel_valid_d && (sel_rd_d != '0);
            if (sel_valid_d) begin
                reg_write_q    <= sel_rd_d;
                write_data_q   <= sel_data_d;
                retire_count_q <= retire_count_q + CNT_W'(1);
            end
        end
    end

    assign write_flag   = write_flag_q;
    assign reg_write    = reg_write_q;
    assign write_data   = write_data_q;
    assign retire_count = retire_count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage: scenario tasks plus randomized traffic against a queue-based model.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_wb_stage;
    import wb_stage_pkg::*;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               ex_valid;
    logic               ex_ready;
    logic [RADDR_W-1:0] ex_rd;
    logic [XLEN-1:0]    ex_data;
    logic               ld_valid;
    logic               ld_ready;
    logic [RADDR_W-1:0] ld_rd;
    logic [2:0]         ld_funct3;
    logic [1:0]         ld_offset;
    logic [XLEN-1:0]    ld_word;
    logic               write_flag;
    logic [RADDR_W-1:0] reg_write;
    logic [XLEN-1:0]    write_data;
    logic [CNT_W-1:0]   retire_count;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    data;
    } ent_t;

    logic               m_flag;
    logic [RADDR_W-1:0] m_rd;
    logic [XLEN-1:0]    m_data;
    logic [CNT_W-1:0]   m_cnt;
    ent_t               m_skid[$];

    always #5 clk_in = ~clk_in;

    wb_stage dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_rd        (ex_rd),
        .ex_data      (ex_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_funct3    (ld_funct3),
        .ld_offset    (ld_offset),
        .ld_word      (ld_word),
        .write_flag   (write_flag),
        .reg_write    (reg_write),
        .write_data   (write_data),
        .retire_count (retire_count)
    );

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_flag = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_cnt  = '0;
        m_skid.delete();
    endtask

    // Advance the model from the inputs currently applied, then step one clock.
    task automatic cycle();
        bit   ldf;
        bit   exf;
        bit   sel;
        ent_t e;
        ldf = ld_valid && rdy_in;
        exf = ex_valid && rdy_in && (m_skid.size() == 0);
        sel = 1'b0;
        e   = '{rd: '0, data: '0};
        if (ldf) begin
            e   = '{rd: ld_rd, data: ref_load(ld_word, ld_funct3, ld_offset)};
            sel = 1'b1;
        end else if (rdy_in && m_skid.size() > 0) begin
            e   = m_skid.pop_front();
            sel = 1'b1;
        end else if (exf) begin
            e   = '{rd: ex_rd, data: ex_data};
            sel = 1'b1;
        end
        if (ldf && exf) m_skid.push_back('{rd: ex_rd, data: ex_data});
        m_flag = sel && (e.rd != 0);
        if (sel) begin
            m_rd   = e.rd;
            m_data = e.data;
            m_cnt  = m_cnt + 1;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in    = 1'b1;
        ex_valid  = 1'b0;
        ex_rd     = '0;
        ex_data   = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_funct3 = F3_LW;
        ld_offset = '0;
        ld_word   = '0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        n_total++;
        if (write_flag !== 1'b0 || reg_write !== '0 || write_data !== '0 || retire_count !== '0)
            $display("FAIL reset_state: got flag=%0b rd=%0d data=%0h cnt=%0d want all zero",
                     write_flag, reg_write, write_data, retire_count);
        else n_pass++;

        ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'hCAFE;
        cycle();
        cycle();
        ld_valid = 1'b1; ld_rd = 5'd8; ld_word = 32'h1111;
        cycle();
        idle_inputs();
        rst_in = 1'b0;
        #1;
        n_total++;
        if (write_flag !== 1'b0 || retire_count !== '0)
            $display("FAIL reset_async: got flag=%0b cnt=%0d want flag=0 cnt=0",
                     write_flag, retire_count);
        else n_pass++;
        #1;
        rst_in = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (ex_ready !== 1'b1)
            $display("FAIL reset_ex_ready: got %0b want 1", ex_ready);
        else n_pass++;
        cycle();
        n_total++;
        if (write_flag !== 1'b0 || retire_count !== '0)
            $display("FAIL reset_skid_discard: got flag=%0b cnt=%0d want flag=0 cnt=0",
                     write_flag, retire_count);
        else n_pass++;
    endtask

    task automatic test_single_ex();
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h1234;
        #1;
        n_total++;
        if (ex_ready !== 1'b1) $display("FAIL single_ex_ready: got %0b want 1", ex_ready);
        else n_pass++;
        cycle();
        ex_valid = 1'b0;
        n_total++;
        if (write_flag !== 1'b1 || reg_write !== 5'd5 || write_data !== 32'h1234
            || retire_count !== m_cnt)
            $display("FAIL single_ex: got flag=%0b rd=%0d data=%0h cnt=%0d want 1/5/1234/%0d",
                     write_flag, reg_write, write_data, retire_count, m_cnt);
        else n_pass++;
    endtask

    task automatic test_collision();
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'hAA;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = F3_LW; ld_offset = 2'd1; ld_word = 32'h55;
        cycle();
        idle_inputs();
        n_total++;
        if (write_flag !== 1'b1 || reg_write !== 5'd4 || write_data !== 32'h55)
            $display("FAIL collision_load: got flag=%0b rd=%0d data=%0h want 1/4/55",
                     write_flag, reg_write, write_data);
        else n_pass++;
        n_total++;
        if (ex_ready !== 1'b0) $display("FAIL collision_ex_ready: got %0b want 0", ex_ready);
        else n_pass++;
        cycle();
        n_total++;
        if (write_flag !== 1'b1 || reg_write !== 5'd3 || write_data !== 32'hAA
            || retire_count !== m_cnt)
            $display("FAIL collision_skid: got flag=%0b rd=%0d data=%0h cnt=%0d want 1/3/aa/%0d",
                     write_flag, reg_write, write_data, retire_count, m_cnt);
        else n_pass++;
    endtask

    task automatic test_extend();
        logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b111};
        logic [1:0]  offs [6] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd3, 2'd2};
        logic [31:0] exps [6] = '{32'hFFFF_FF82, 32'h0000_0080, 32'hFFFF_80F1,
                                  32'h0000_7F82, 32'hFFFF_80F1, 32'h80F1_7F82};
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1; ld_rd = 5'd20; ld_word = 32'h80F1_7F82;
            ld_funct3 = f3s[i]; ld_offset = offs[i];
            cycle();
            n_total++;
            if (write_data !== exps[i] || write_data !== m_data || write_flag !== 1'b1)
                $display("FAIL extend_%0d: got flag=%0b data=%0h want 1/%0h",
                         i, write_flag, write_data, exps[i]);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_x0_pause();
        logic [CNT_W-1:0] c0;
        c0 = retire_count;
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hDEAD;
        cycle();
        idle_inputs();
        n_total++;
        if (write_flag !== 1'b0 || retire_count !== c0 + 1 || write_data !== 32'hDEAD)
            $display("FAIL x0_write: got flag=%0b cnt=%0d data=%0h want 0/%0d/dead",
                     write_flag, retire_count, write_data, c0 + 1);
        else n_pass++;

        ex_valid = 1'b1; ex_rd = 5'd9;  ex_data = 32'h9999;
        ld_valid = 1'b1; ld_rd = 5'd10; ld_word = 32'hA0A0;
        cycle();
        idle_inputs();
        rdy_in = 1'b0;
        cycle();
        n_total++;
        if (write_flag !== 1'b0 || ld_ready !== 1'b0)
            $display("FAIL pause_no_write: got flag=%0b ld_ready=%0b want 0/0", write_flag, ld_ready);
        else n_pass++;
        cycle();
        n_total++;
        if (write_flag !== 1'b0 || ex_ready !== 1'b0 || reg_write !== 5'd10)
            $display("FAIL pause_hold: got flag=%0b ex_ready=%0b rd=%0d want 0/0/10",
                     write_flag, ex_ready, reg_write);
        else n_pass++;
        rdy_in = 1'b1;
        cycle();
        n_total++;
        if (write_flag !== 1'b1 || reg_write !== 5'd9 || write_data !== 32'h9999)
            $display("FAIL pause_drain: got flag=%0b rd=%0d data=%0h want 1/9/9999",
                     write_flag, reg_write, write_data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] c0;
        c0 = retire_count;
        ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 32'h0C0C;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_rd = 5'(13 + i); ld_funct3 = F3_LW; ld_word = 32'(i + 100);
            cycle();
            ex_valid = 1'b0;
            n_total++;
            if (write_flag !== 1'b1 || reg_write !== 5'(13 + i) || write_data !== 32'(i + 100))
                $display("FAIL b2b_load_%0d: got rd=%0d data=%0h want %0d/%0h",
                         i, reg_write, write_data, 13 + i, i + 100);
            else n_pass++;
        end
        idle_inputs();
        cycle();
        n_total++;
        if (write_flag !== 1'b1 || reg_write !== 5'd12 || write_data !== 32'h0C0C
            || retire_count !== c0 + 4)
            $display("FAIL b2b_ex: got rd=%0d data=%0h cnt=%0d want 12/c0c/%0d",
                     reg_write, write_data, retire_count, c0 + 4);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ex_hold = 1'b0;
        bit ld_hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!ex_hold) begin
                ex_valid = 1'($urandom);
                ex_rd    = 5'($urandom);
                ex_data  = $urandom;
            end
            if (!ld_hold) begin
                ld_valid  = 1'($urandom);
                ld_rd     = 5'($urandom);
                ld_funct3 = 3'($urandom);
                ld_offset = 2'($urandom);
                ld_word   = $urandom;
            end
            rdy_in = ($urandom_range(0, 3) != 0);
            #1;
            n_total++;
            if (ex_ready !== (rdy_in && m_skid.size() == 0) || ld_ready !== rdy_in)
                $display("FAIL rand_ready_%0d: got ex=%0b ld=%0b want ex=%0b ld=%0b",
                         i, ex_ready, ld_ready, rdy_in && m_skid.size() == 0, rdy_in);
            else n_pass++;
            ex_hold = ex_valid && !(rdy_in && m_skid.size() == 0);
            ld_hold = ld_valid && !rdy_in;
            cycle();
            n_total++;
            if (write_flag !== m_flag || reg_write !== m_rd || write_data !== m_data
                || retire_count !== m_cnt)
                $display("FAIL rand_port_%0d: got %0b/%0d/%0h/%0d want %0b/%0d/%0h/%0d", i,
                         write_flag, reg_write, write_data, retire_count,
                         m_flag, m_rd, m_data, m_cnt);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_ex();
        test_collision();
        test_extend();
        test_x0_pause();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
